transfer_register_v1: RTL and testbench

TRANSFER_REGISTER_V1 -- requirements
Module: transfer_register_v1

---
 rtl/transfer_register_v1.sv | 55 +++++
 tb/tb_transfer_register_v1.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/transfer_register_v1.sv
// transfer_register_v1: 16-bit transfer register T with byte/word loads
// and tri-state drivers onto Addr, Bus and MainBus.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset, T <= RESET_VAL
//   Addr         tri-state output, T while a_tx_addr_n=0
//   Bus          16-bit inout, T while a_tx_xfer_n=0
//   MainBus      8-bit inout, T[15:8] (a_th_n) or T[7:0] (a_tl_n)
//   l_th_n       load T[15:8] from MainBus (active low)
//   l_tl_n       load T[7:0] from MainBus (active low)
//   l_tx_n       load T from Bus (active low, wins over byte loads)
//   a_th_n       drive T[15:8] onto MainBus (active low, wins over a_tl_n)
//   a_tl_n       drive T[7:0] onto MainBus (active low)
//   a_tx_addr_n  drive T onto Addr (active low)
//   a_tx_xfer_n  drive T onto Bus (active low)
module transfer_register_v1 #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output wire  [15:0] Addr,
    inout  wire  [15:0] Bus,
    inout  wire  [7:0]  MainBus,
    input  logic        l_th_n,
    input  logic        l_tl_n,
    input  logic        l_tx_n,
    input  logic        a_th_n,
    input  logic        a_tl_n,
    input  logic        a_tx_addr_n,
    input  logic        a_tx_xfer_n
);

    logic [15:0] t;

    // Loads sample the resolved bus, so asserting and loading the same
    // bus in one cycle just recaptures T.
    always_ff @(posedge clk) begin
        if (rst) begin
            t <= RESET_VAL;
        end else if (!l_tx_n) begin
            t <= Bus;
        end else begin
            if (!l_th_n) t[15:8] <= MainBus;
            if (!l_tl_n) t[7:0]  <= MainBus;
        end
    end

    // Drivers are independent of rst and follow the current T.
    assign Addr    = !a_tx_addr_n ? t : 16'hzzzz;
    assign Bus     = !a_tx_xfer_n ? t : 16'hzzzz;
    assign MainBus = !a_th_n ? t[15:8] :
                     !a_tl_n ? t[7:0]  : 8'hzz;

endmodule

// File: tb/tb_transfer_register_v1.sv
// Directed bench for transfer_register_v1. Undriven buses are pulled
// high, so a released bus reads as all ones.
module tb_transfer_register_v1;

    logic clk = 1'b0;
    logic rst;
    logic l_th_n, l_tl_n, l_tx_n;
    logic a_th_n, a_tl_n, a_tx_addr_n, a_tx_xfer_n;

    wire [15:0] Addr;
    wire [15:0] Bus;
    wire [7:0]  MainBus;

    logic [15:0] bus_drv;
    logic        bus_oe;
    logic [7:0]  mb_drv;
    logic        mb_oe;

    int n_chk  = 0;
    int n_pass = 0;

    assign Bus     = bus_oe ? bus_drv : 16'hzzzz;
    assign MainBus = mb_oe  ? mb_drv  : 8'hzz;

    pullup (Addr);
    pullup (Bus);
    pullup (MainBus);

    always #5 clk = ~clk;

    transfer_register_v1 #(.RESET_VAL(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .Addr       (Addr),
        .Bus        (Bus),
        .MainBus    (MainBus),
        .l_th_n     (l_th_n),
        .l_tl_n     (l_tl_n),
        .l_tx_n     (l_tx_n),
        .a_th_n     (a_th_n),
        .a_tl_n     (a_tl_n),
        .a_tx_addr_n(a_tx_addr_n),
        .a_tx_xfer_n(a_tx_xfer_n)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        l_th_n = 1'b1; l_tl_n = 1'b1; l_tx_n = 1'b1;
        a_th_n = 1'b1; a_tl_n = 1'b1;
        a_tx_addr_n = 1'b1; a_tx_xfer_n = 1'b1;
        bus_oe = 1'b0; mb_oe = 1'b0;
        #1;
    endtask

    task automatic load_word(input logic [15:0] v);
        bus_drv = v; bus_oe = 1'b1; l_tx_n = 1'b0;
        tick();
        idle();
    endtask

    task automatic peek_t(input string tag, input logic [15:0] exp);
        a_tx_addr_n = 1'b0;
        #1;
        check(tag, Addr, exp);
        a_tx_addr_n = 1'b1;
        #1;
    endtask

    initial begin
        bus_drv = '0; mb_drv = '0;
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        tick();

        // Idle: everything floats, T is the reset value
        check("idle_addr_z", Addr, 16'hFFFF);
        check("idle_bus_z", Bus, 16'hFFFF);
        check("idle_mb_z", {8'h00, MainBus}, 16'h00FF);
        peek_t("reset_t", 16'h0000);

        // Byte loads from MainBus
        mb_drv = 8'h55; mb_oe = 1'b1; l_th_n = 1'b0;
        tick();
        idle();
        mb_drv = 8'hAA; mb_oe = 1'b1; l_tl_n = 1'b0;
        tick();
        idle();
        peek_t("byte_loads", 16'h55AA);
        check("addr_release_z", Addr, 16'hFFFF);

        // Word load from Bus, then each driver
        load_word(16'h1234);
        a_tx_xfer_n = 1'b0;
        #1;
        check("bus_drive", Bus, 16'h1234);
        a_th_n = 1'b0;
        #1;
        check("mb_hi", {8'h00, MainBus}, 16'h0012);
        a_th_n = 1'b1; a_tl_n = 1'b0;
        #1;
        check("mb_lo", {8'h00, MainBus}, 16'h0034);
        idle();

        // l_tx_n wins over l_th_n
        bus_drv = 16'h5678; bus_oe = 1'b1; l_tx_n = 1'b0;
        mb_drv = 8'hFF; mb_oe = 1'b1; l_th_n = 1'b0;
        tick();
        idle();
        peek_t("tx_priority", 16'h5678);

        // Both byte strobes in one edge
        mb_drv = 8'h3C; mb_oe = 1'b1; l_th_n = 1'b0; l_tl_n = 1'b0;
        tick();
        idle();
        peek_t("both_bytes", 16'h3C3C);

        // Hold with no strobes
        tick();
        tick();
        peek_t("hold", 16'h3C3C);

        // New value appears only after the loading edge
        a_tx_addr_n = 1'b0;
        bus_drv = 16'h9999; bus_oe = 1'b1; l_tx_n = 1'b0;
        #1;
        check("pre_edge", Addr, 16'h3C3C);
        tick();
        check("post_edge", Addr, 16'h9999);
        idle();

        // Self-load from Bus and MainBus keeps T
        a_tx_xfer_n = 1'b0; l_tx_n = 1'b0;
        tick();
        idle();
        a_tl_n = 1'b0; l_th_n = 1'b0;
        tick();
        idle();
        peek_t("self_load", 16'h9999);

        // Reset discards a simultaneous load
        load_word(16'h55AA);
        rst = 1'b1;
        mb_drv = 8'h11; mb_oe = 1'b1; l_tl_n = 1'b0;
        tick();
        rst = 1'b0;
        idle();
        peek_t("rst_over_load", 16'h0000);

        // Drivers stay live during reset
        load_word(16'hBEEF);
        rst = 1'b1; a_tx_addr_n = 1'b0;
        #1;
        check("rst_drive_pre", Addr, 16'hBEEF);
        tick();
        check("rst_drive_post", Addr, 16'h0000);
        rst = 1'b0;
        idle();

        // a_th_n wins over a_tl_n; all drivers at once
        load_word(16'hBEEF);
        a_th_n = 1'b0; a_tl_n = 1'b0;
        a_tx_addr_n = 1'b0; a_tx_xfer_n = 1'b0;
        #1;
        check("mb_th_wins", {8'h00, MainBus}, 16'h00BE);
        check("conc_addr", Addr, 16'hBEEF);
        check("conc_bus", Bus, 16'hBEEF);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
